// File: rtl/maddness_pkg.sv
// Shared definitions for the MADDNESS coefficient memory: sizing, section offsets
// and the loader FSM state encoding.
package maddness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int memsize_f(input int layers, input int trees, input int output_len);
        return layers * trees + ((1 << layers) - 1) * trees + trees * output_len * (1 << layers);
    endfunction

    // Section base addresses, used by hosts to pick cfg_base for partial loads.
    function automatic int idx_offset();
        return 0;
    endfunction

    function automatic int val_offset(input int layers, input int trees);
        return layers * trees;
    endfunction

    function automatic int res_offset(input int layers, input int trees);
        return layers * trees + ((1 << layers) - 1) * trees;
    endfunction

endpackage

// File: rtl/maddness_loader.sv
// Streams words from the host link into the MADDNESS coefficient memory at
// base+k, then compares a trailing checksum word against the running sum.
module maddness_loader
    import maddness_pkg::*;
#(
    parameter int layers     = 4,
    parameter int trees      = 4,
    parameter int output_len = 8,
    parameter int bits       = 8,
    localparam int memsize   = memsize_f(layers, trees, output_len),
    localparam int addr_len  = clog2(memsize)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [addr_len-1:0] cfg_base,
    input  logic [addr_len:0]   cfg_len,
    input  logic [bits-1:0]     s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [bits-1:0]     in_num,
    output logic [addr_len-1:0] in_addr,
    output logic                write,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Handshake: a stream word transfers on a rising edge where s_valid and
    // s_ready are both high; s_ready depends only on the FSM state.

    state_t              state;
    logic [addr_len-1:0] base;
    logic [addr_len:0]   len;
    logic [addr_len:0]   k;
    logic [bits-1:0]     sum;

    logic [addr_len:0]   eff_len;
    logic [addr_len+1:0] end_addr;
    logic                range_bad;

    // One extra bit beyond addr_len+1 so an oversized cfg_len cannot wrap.
    assign eff_len   = (cfg_len == '0) ? (addr_len+1)'(memsize) : cfg_len;
    assign end_addr  = {2'b00, cfg_base} + {1'b0, eff_len};
    assign range_bad = end_addr > (addr_len+2)'(memsize);

    assign s_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign busy    = (state == ST_LOAD) || (state == ST_CHECK);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            base    <= '0;
            len     <= '0;
            k       <= '0;
            sum     <= '0;
            in_num  <= '0;
            in_addr <= '0;
            write   <= 1'b0;
            err     <= 1'b0;
        end else begin
            write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base  <= cfg_base;
                        len   <= eff_len;
                        k     <= '0;
                        sum   <= '0;
                        err   <= range_bad;
                        state <= range_bad ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        in_num  <= s_data;
                        in_addr <= base + k[addr_len-1:0];
                        write   <= 1'b1;
                        sum     <= sum + s_data;
                        k       <= k + 1'b1;
                        if (k == len - 1'b1) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (s_valid) begin
                        if (s_data != sum) begin
                            err <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maddness_loader.sv
// Directed table-driven bench for maddness_loader with hand-computed checksums
// and a write scoreboard checked every cycle.
module tb_maddness_loader;

    localparam int AL = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AL-1:0] cfg_base;
    logic [AL:0]   cfg_len;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    in_num;
    logic [AL-1:0] in_addr;
    logic          write;
    logic          busy;
    logic          done;
    logic          err;

    maddness_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .in_num   (in_num),
        .in_addr  (in_addr),
        .write    (write),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [AL-1:0] base;
        logic [AL:0]   len;
        int            pat;
        logic [7:0]    ck;
        logic          exp_err;
        logic          exp_range;
        logic          bp;
    } vec_t;

    vec_t              vecs[10];
    logic [AL+7:0]     exp_q[$];
    int                n_vec;
    int                n_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then score any memory write visible in the new cycle.
    task automatic step();
        logic [AL+7:0] e;
        @(posedge clk);
        #1;
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {14'd0, in_addr, in_num}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("write_a%0d", e[AL+7:8]), {14'd0, in_addr, in_num}, {14'd0, e});
            end
        end
    endtask

    task automatic do_start(input logic [AL-1:0] b, input logic [AL:0] l);
        start    = 1'b1;
        cfg_base = b;
        cfg_len  = l;
        step();
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic bp);
        logic ok;
        int   n;
        if (bp) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) step();
        end
        s_valid = 1'b1;
        s_data  = d;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = s_ready;
            step();
        end
        if (!ok) chk("beat_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat_word(input int pat, input int k);
        logic [31:0] v;
        case (pat)
            0:       v = k;
            1:       v = 32'hA5;
            default: v = k * 7 + 3;
        endcase
        return v[7:0];
    endfunction

    task automatic run_vec(input int idx);
        vec_t          v;
        int            eff;
        logic [AL-1:0] a;
        logic [7:0]    d;
        v = vecs[idx];
        do_start(v.base, v.len);
        if (v.exp_range) begin
            chk($sformatf("v%0d_range_done", idx), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d_range_err", idx), {31'd0, err}, 32'd1);
            chk($sformatf("v%0d_range_ready", idx), {31'd0, s_ready}, 32'd0);
            chk($sformatf("v%0d_range_busy", idx), {31'd0, busy}, 32'd0);
            step();
            chk($sformatf("v%0d_range_done_fall", idx), {31'd0, done}, 32'd0);
            step();
            return;
        end
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_ready", idx), {31'd0, s_ready}, 32'd1);
        chk($sformatf("v%0d_err_clr", idx), {31'd0, err}, 32'd0);
        eff = (v.len == 0) ? 588 : int'(v.len);
        for (int k = 0; k < eff; k++) begin
            d = pat_word(v.pat, k);
            a = v.base + AL'(k);
            exp_q.push_back({a, d});
            send_beat(d, v.bp);
        end
        send_beat(v.ck, v.bp);
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_busy_fall", idx), {31'd0, busy}, 32'd0);
        step();
        chk($sformatf("v%0d_done_fall", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_err_sticky", idx), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_q_empty", idx), exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_in_num"}, {24'd0, in_num}, 32'd0);
        chk({tag, "_in_addr"}, {22'd0, in_addr}, 32'd0);
        chk({tag, "_write"}, {31'd0, write}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_base = '0;
        cfg_len  = '0;
        s_data   = '0;
        s_valid  = 1'b0;

        //            base     len      pat ck     err   range bp
        vecs[0] = '{10'd0,   11'd0,    0, 8'h22, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{10'd16,  11'd60,   1, 8'hCC, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{10'd16,  11'd60,   1, 8'hAC, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{10'd580, 11'd16,   0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{10'd200, 11'd10,   2, 8'h59, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{10'd587, 11'd1,    0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{10'd1,   11'd0,    0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{10'd0,   11'd2047, 0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{10'd512, 11'd76,   0, 8'h22, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{10'd76,  11'd512,  0, 8'h00, 1'b0, 1'b0, 1'b1};

        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec(i);
        end

        // Reset in the middle of a load aborts immediately.
        do_start(10'd300, 11'd20);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({AL'(300 + k), 8'(k + 8'h40)});
            send_beat(8'(k + 8'h40), 1'b0);
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        chk("mid_q_empty", exp_q.size(), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Fresh load afterwards, with start pulses during LOAD ignored.
        do_start(10'd40, 11'd4);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({AL'(40 + k), 8'(k + 1)});
            if (k == 1) begin
                start    = 1'b1;
                cfg_base = 10'd0;
                cfg_len  = 11'd1;
            end
            send_beat(8'(k + 1), 1'b0);
            start = 1'b0;
        end
        send_beat(8'h0A, 1'b0);
        chk("reload_done", {31'd0, done}, 32'd1);
        chk("reload_err", {31'd0, err}, 32'd0);
        step();
        chk("reload_q_empty", exp_q.size(), 32'd0);
        step();
        step();
        chk("final_idle_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
